// File: rtl/sha0_pkg.sv
// Shared types and constants for the SHA-0 job arbiter slice.
package sha0_pkg;

    localparam int SHA0_DIGEST_W = 160;
    localparam int SHA0_MAX_LEN  = 64;

    typedef logic [SHA0_DIGEST_W-1:0] digest_t;

    typedef logic [2:0] state_t;
    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_START  = 3'd1;
    localparam state_t S_STREAM = 3'd2;
    localparam state_t S_WAIT   = 3'd3;
    localparam state_t S_RESP   = 3'd4;

endpackage

// File: rtl/sha0_job_arbiter_rr.sv
// Combinational round-robin picker: first request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  id,
    output logic            any
);

    logic [IDW-1:0] idx;

    always_comb begin
        grant = '0;
        id    = '0;
        any   = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = IDW'((32'(ptr) + i) % NREQ);
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                id         = idx;
            end
        end
    end

endmodule

// File: rtl/sha0_job_arbiter.sv
// Shares one sha0_core among NREQ requesters: round-robin grant, byte streaming,
// digest return tagged with requester id, watchdog abort.
module sha0_job_arbiter
    import sha0_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int MAX_LEN = SHA0_MAX_LEN,
    parameter int TIMEOUT = 4096
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [16*NREQ-1:0]       req_len,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ-1:0]          req_dvalid,
    input  logic [8*NREQ-1:0]        req_data,
    output logic [NREQ-1:0]          req_dready,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [$clog2(NREQ)-1:0]  resp_id,
    output logic [SHA0_DIGEST_W-1:0] resp_digest,
    output logic                     resp_err,
    output logic                     core_start,
    output logic [15:0]              core_msg_len,
    input  logic                     core_busy,
    output logic                     core_in_valid,
    output logic [7:0]               core_in_data,
    input  logic                     core_in_ready,
    input  logic                     core_digest_valid,
    input  logic [31:0]              core_digest0,
    input  logic [31:0]              core_digest1,
    input  logic [31:0]              core_digest2,
    input  logic [31:0]              core_digest3,
    input  logic [31:0]              core_digest4
);

    localparam int IDW = $clog2(NREQ);
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [15:0] MAX_LEN16 = 16'(MAX_LEN);

    state_t          state;
    logic [IDW-1:0]  id_q;
    logic [IDW-1:0]  rr_ptr;
    logic [NREQ-1:0] own_q;
    logic [15:0]     len_q;
    logic [15:0]     cnt;
    logic [WDW-1:0]  wd;

    logic [NREQ-1:0] gnt_onehot;
    logic [IDW-1:0]  gnt_id;
    logic            gnt_any;
    logic [15:0]     sel_len;
    logic [7:0]      sel_data;
    logic            xfer;
    logic            timeout;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (gnt_onehot),
        .id    (gnt_id),
        .any   (gnt_any)
    );

    always_comb begin
        sel_len  = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (IDW'(i) == gnt_id) sel_len  = req_len[16*i +: 16];
            if (IDW'(i) == id_q)   sel_data = req_data[8*i +: 8];
        end
    end

    // own_q masks every per-requester output so non-granted lanes stay quiet
    assign core_start    = (state == S_START);
    assign core_msg_len  = len_q;
    assign core_in_valid = (state == S_STREAM) && (|(req_dvalid & own_q)) && (cnt < len_q);
    assign core_in_data  = (state == S_STREAM) ? sel_data : '0;
    assign xfer          = core_in_valid && core_in_ready;
    assign req_dready    = xfer ? own_q : '0;
    assign req_ready     = (state == S_START) ? own_q : '0;
    assign resp_valid    = (state == S_RESP);
    assign resp_id       = id_q;
    assign timeout       = (wd == WDW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            id_q        <= '0;
            rr_ptr      <= '0;
            own_q       <= '0;
            len_q       <= '0;
            cnt         <= '0;
            wd          <= '0;
            resp_digest <= '0;
            resp_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (gnt_any && !core_busy) begin
                        id_q  <= gnt_id;
                        own_q <= gnt_onehot;
                        len_q <= (sel_len > MAX_LEN16) ? MAX_LEN16 : sel_len;
                        wd    <= '0;
                        state <= S_START;
                    end
                end
                S_START: begin
                    cnt   <= '0;
                    wd    <= wd + WDW'(1);
                    state <= (len_q == 16'd0) ? S_WAIT : S_STREAM;
                end
                S_STREAM: begin
                    wd <= wd + WDW'(1);
                    if (xfer) cnt <= cnt + 16'd1;
                    if (timeout) begin
                        resp_digest <= '0;
                        resp_err    <= 1'b1;
                        state       <= S_RESP;
                    end else if (xfer && (cnt + 16'd1 == len_q)) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    wd <= wd + WDW'(1);
                    // a digest arriving on the timeout cycle still wins
                    if (core_digest_valid) begin
                        resp_digest <= {core_digest0, core_digest1, core_digest2,
                                        core_digest3, core_digest4};
                        resp_err    <= 1'b0;
                        state       <= S_RESP;
                    end else if (timeout) begin
                        resp_digest <= '0;
                        resp_err    <= 1'b1;
                        state       <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        rr_ptr <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha0_job_arbiter.sv
// Scoreboard bench: requester models, a behavioural SHA-0 core stub and a response monitor.
module tb_sha0_job_arbiter;

    localparam int NREQ    = 4;
    localparam int MAX_LEN = 64;
    localparam int TIMEOUT = 300;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid, req_ready, req_dvalid, req_dready;
    logic [16*NREQ-1:0]  req_len;
    logic [8*NREQ-1:0]   req_data;
    logic                resp_valid, resp_ready, resp_err;
    logic [1:0]          resp_id;
    logic [159:0]        resp_digest;
    logic                core_start, core_busy, core_in_valid, core_in_ready, core_digest_valid;
    logic [15:0]         core_msg_len;
    logic [7:0]          core_in_data;
    logic [31:0]         core_digest0, core_digest1, core_digest2, core_digest3, core_digest4;

    sha0_job_arbiter #(.NREQ(NREQ), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_len(req_len), .req_ready(req_ready),
        .req_dvalid(req_dvalid), .req_data(req_data), .req_dready(req_dready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_digest(resp_digest), .resp_err(resp_err),
        .core_start(core_start), .core_msg_len(core_msg_len), .core_busy(core_busy),
        .core_in_valid(core_in_valid), .core_in_data(core_in_data), .core_in_ready(core_in_ready),
        .core_digest_valid(core_digest_valid),
        .core_digest0(core_digest0), .core_digest1(core_digest1), .core_digest2(core_digest2),
        .core_digest3(core_digest3), .core_digest4(core_digest4)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           len;
        int           seed;
        bit           use_const;
        logic [159:0] cdig;
    } job_t;

    typedef struct {
        int           id;
        logic [159:0] dig;
        bit           err;
        int           drawn;
        longint       t0;
    } exp_t;

    localparam logic [159:0] DIG_ABC   = 160'h0164b8a9_14cd2a5e_74c4f7ff_082c4d97_f1edf880;
    localparam logic [159:0] DIG_EMPTY = 160'hf96cea19_8ad1dd56_17ac084a_3d92c610_7708c0ef;

    int          errors = 0;
    int          checks = 0;
    job_t        pend_job [NREQ];
    bit          pend_v   [NREQ];
    job_t        act_job;
    int          act_id  = -1;
    int          act_pos = 0;
    exp_t        exp_q[$];
    int          rr_model = 0;
    bit          hang     = 1'b0;
    bit          rr_mode  = 1'b1;
    int          grant_log[$];
    int          stub_st  = 0;
    int          stub_len = 0;
    int          stub_delay = 0;
    logic [7:0]  stub_buf[$];

    task automatic chk(input string name, input logic [199:0] got, input logic [199:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    function automatic logic [7:0] byte_of(input int seed, input int k);
        if (seed == 0) return 8'(8'h61 + k);
        return 8'(seed * 37 + k * 11 + k * k * 3);
    endfunction

    function automatic logic [511:0] job_bytes(input int seed, input int n);
        logic [511:0] m = '0;
        for (int k = 0; k < n; k++) m[8*k +: 8] = byte_of(seed, k);
        return m;
    endfunction

    // Straight SHA-0 from the FIPS-180 description: padding, 80-round compression, no schedule rotate.
    function automatic logic [159:0] sha0_ref(input logic [511:0] m, input int n);
        logic [7:0]  blk [128];
        logic [31:0] w   [80];
        logic [31:0] h   [5];
        logic [31:0] a, b, c, d, e, f, k, tmp;
        int          nb;
        longint      bits;
        nb = (n <= 55) ? 1 : 2;
        for (int i = 0; i < 128; i++) begin
            blk[i] = 8'h00;
            if (i < n) blk[i] = m[8*i +: 8];
        end
        blk[n] = 8'h80;
        bits = longint'(n) * 8;
        for (int j = 0; j < 8; j++) blk[nb*64-1-j] = 8'(bits >> (8*j));
        h[0] = 32'h67452301; h[1] = 32'hEFCDAB89; h[2] = 32'h98BADCFE;
        h[3] = 32'h10325476; h[4] = 32'hC3D2E1F0;
        for (int bi = 0; bi < nb; bi++) begin
            for (int t = 0; t < 16; t++)
                w[t] = {blk[bi*64+4*t], blk[bi*64+4*t+1], blk[bi*64+4*t+2], blk[bi*64+4*t+3]};
            for (int t = 16; t < 80; t++) w[t] = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
            a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4];
            for (int t = 0; t < 80; t++) begin
                if (t < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
                else if (t < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
                else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
                else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
                tmp = {a[26:0], a[31:27]} + f + e + k + w[t];
                e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = tmp;
            end
            h[0] += a; h[1] += b; h[2] += c; h[3] += d; h[4] += e;
        end
        return {h[0], h[1], h[2], h[3], h[4]};
    endfunction

    function automatic int exp_grant(input logic [NREQ-1:0] v);
        for (int k2 = 0; k2 < NREQ; k2++)
            if (v[(rr_model + k2) % NREQ]) return (rr_model + k2) % NREQ;
        return -1;
    endfunction

    // Input driver and core stub outputs, updated just after each rising edge.
    initial begin : drive
        logic [511:0] m;
        req_valid = '0; req_len = '0; req_dvalid = '0; req_data = '0;
        resp_ready = 1'b0; core_busy = 1'b0; core_in_ready = 1'b0; core_digest_valid = 1'b0;
        core_digest0 = '0; core_digest1 = '0; core_digest2 = '0; core_digest3 = '0; core_digest4 = '0;
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++) begin
                req_valid[i] = pend_v[i];
                req_len[16*i +: 16] = pend_v[i] ? 16'(pend_job[i].len) : 16'($urandom);
                if (i == act_id) begin
                    req_dvalid[i] = (act_pos < act_job.len) && ($urandom_range(0, 7) != 0);
                    req_data[8*i +: 8] = byte_of(act_job.seed, act_pos);
                end else begin
                    req_dvalid[i] = ($urandom_range(0, 3) == 0);
                    req_data[8*i +: 8] = 8'($urandom);
                end
            end
            core_busy     = (stub_st != 0);
            core_in_ready = ($urandom_range(0, 7) != 0);
            resp_ready    = rr_mode ? 1'b1 : ($urandom_range(0, 2) != 0);
            core_digest_valid = 1'b0;
            if (stub_st == 2) begin
                stub_delay--;
                if (stub_delay == 0) begin
                    m = '0;
                    for (int j = 0; j < stub_buf.size(); j++) m[8*j +: 8] = stub_buf[j];
                    {core_digest0, core_digest1, core_digest2, core_digest3, core_digest4} =
                        sha0_ref(m, stub_len);
                    core_digest_valid = 1'b1;
                    stub_st = 0;
                end
            end else begin
                core_digest0 = $urandom; core_digest1 = $urandom; core_digest2 = $urandom;
                core_digest3 = $urandom; core_digest4 = $urandom;
            end
        end
    end

    // Handshake observer: grant model, byte accounting, core stub input side, scoreboard push.
    initial begin : observe
        logic [NREQ-1:0] prev_valid;
        logic [NREQ-1:0] want;
        logic [NREQ-1:0] own;
        int              eg, gi, n;
        exp_t            e;
        prev_valid = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stub_st = 0; act_id = -1; act_pos = 0; rr_model = 0;
                exp_q.delete(); stub_buf.delete(); prev_valid = '0;
            end else begin
                if (req_ready != '0) begin
                    eg = exp_grant(prev_valid);
                    want = '0;
                    if (eg >= 0) want[eg] = 1'b1;
                    chk("grant", 200'(req_ready), 200'(want));
                    gi = 0;
                    for (int i = NREQ - 1; i >= 0; i--) if (req_ready[i]) gi = i;
                    act_id = gi; act_job = pend_job[gi]; act_pos = 0; pend_v[gi] = 1'b0;
                    grant_log.push_back(gi);
                    n = (act_job.len > MAX_LEN) ? MAX_LEN : act_job.len;
                    e.id = gi; e.drawn = n; e.t0 = cyc;
                    if (hang) begin
                        e.err = 1'b1; e.dig = '0;
                    end else begin
                        e.err = 1'b0;
                        e.dig = act_job.use_const ? act_job.cdig : sha0_ref(job_bytes(act_job.seed, n), n);
                    end
                    exp_q.push_back(e);
                end
                own = '0;
                if (act_id >= 0) own[act_id] = 1'b1;
                if ((req_dvalid & ~own) != '0) chk("dready_owner", 200'(req_dready & ~own), '0);
                if (act_id >= 0 && req_dready[act_id]) act_pos++;
                if (core_start) begin
                    stub_st = 1; stub_len = int'(core_msg_len); stub_buf.delete();
                end
                if (stub_st == 1 && core_in_valid && core_in_ready) stub_buf.push_back(core_in_data);
                if (stub_st == 1 && !hang && stub_buf.size() == stub_len) begin
                    stub_st = 2; stub_delay = $urandom_range(1, 4);
                end
                prev_valid = req_valid;
            end
        end
    end

    // Response monitor: pops the scoreboard on every accepted digest.
    initial begin : monitor
        bit     prev_rv;
        longint rise;
        exp_t   e;
        prev_rv = 1'b0; rise = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_rv = 1'b0;
            end else begin
                if (resp_valid && !prev_rv) rise = cyc;
                if (resp_valid && resp_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_resp: got id %0d with no job outstanding", resp_id);
                    end else begin
                        e = exp_q.pop_front();
                        chk("resp_id", 200'(resp_id), 200'(e.id));
                        chk("resp_digest", 200'(resp_digest), 200'(e.dig));
                        chk("resp_err", 200'(resp_err), 200'(e.err));
                        chk("bytes_drawn", 200'(act_pos), 200'(e.drawn));
                        if (e.err) chk("timeout_cycles", 200'(rise - e.t0), 200'(TIMEOUT));
                        rr_model = (e.id + 1) % NREQ;
                    end
                end
                prev_rv = resp_valid;
            end
        end
    end

    task automatic submit(input int i, input int len, input int seed, input bit uc, input logic [159:0] cd);
        pend_job[i] = '{len: len, seed: seed, use_const: uc, cdig: cd};
        pend_v[i] = 1'b1;
    endtask

    function automatic bit busy_any();
        for (int i = 0; i < NREQ; i++) if (pend_v[i]) return 1'b1;
        return (exp_q.size() != 0);
    endfunction

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy_any() && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= budget) begin
            checks++; errors++;
            $display("FAIL %s: still busy after %0d cycles, want idle", name, budget);
        end
    endtask

    task automatic check_reset(input string name);
        chk(name, 200'({req_ready, req_dready, resp_valid, resp_id, resp_digest, resp_err,
                        core_start, core_msg_len, core_in_valid, core_in_data}), '0);
    endtask

    initial begin : main
        int n, i;
        logic [14:0] order;
        for (int r = 0; r < NREQ; r++) pend_v[r] = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset_outputs");
        #2 rst_n = 1'b1;
        @(negedge clk); #1;

        // All four requesters at once, second job from req0 queued behind
        rr_mode = 1'b1;
        grant_log.delete();
        submit(0, 3, 0, 1'b1, DIG_ABC);
        submit(1, 3, 11, 1'b0, '0);
        submit(2, 3, 22, 1'b0, '0);
        submit(3, 3, 33, 1'b0, '0);
        n = 0;
        while (pend_v[0] && n < 200) begin @(negedge clk); #1; n++; end
        submit(0, 3, 44, 1'b0, '0);
        wait_idle("round_robin", 3000);
        order = '0;
        for (int k = 0; k < 5; k++) order[3*k +: 3] = (k < grant_log.size()) ? 3'(grant_log[k]) : 3'h7;
        chk("grant_order", 200'(order), 200'({3'd0, 3'd3, 3'd2, 3'd1, 3'd0}));

        rr_mode = 1'b0;
        submit(2, 0, 5, 1'b1, DIG_EMPTY);
        wait_idle("zero_len", 500);

        submit(1, 100, 77, 1'b0, '0);
        wait_idle("over_max_len", 1000);

        for (int j = 0; j < 40; j++) begin
            i = $urandom_range(0, NREQ - 1);
            if (!pend_v[i])
                submit(i, ($urandom_range(0, 3) == 0) ? $urandom_range(56, 90) : $urandom_range(0, 55),
                       $urandom_range(1, 1000), 1'b0, '0);
            repeat ($urandom_range(0, 30)) @(negedge clk);
            #1;
        end
        wait_idle("random", 20000);

        hang = 1'b1;
        submit(2, 3, 5, 1'b0, '0);
        wait_idle("timeout", TIMEOUT + 200);
        hang = 1'b0;
        stub_st = 0;

        submit(1, 60, 9, 1'b0, '0);
        n = 0;
        while (!(act_id == 1 && act_pos >= 10) && n < 500) begin @(negedge clk); #1; n++; end
        if (n >= 500) begin
            checks++; errors++;
            $display("FAIL mid_stream_wait: act_pos %0d, want >= 10", act_pos);
        end
        rst_n = 1'b0;
        for (int r = 0; r < NREQ; r++) pend_v[r] = 1'b0;
        @(negedge clk); #1;
        check_reset("reset_mid_stream");
        rst_n = 1'b1;
        @(negedge clk); #1;
        submit(3, 3, 0, 1'b1, DIG_ABC);
        wait_idle("after_reset", 500);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL global_timeout: simulation time limit reached, errors=%0d of %0d checks", errors, checks);
        $fatal(1, "time limit");
    end

endmodule
